// File: rtl/spi_display_rx_if.sv
// Pin bundle between an SPI display-link source/consumer and spi_display_rx.
// SPI_DISPLAY_RX_STATS_EN adds the bytes/aborts statistics outputs.
interface spi_display_rx_if;
    logic       spi_cs_n;
    logic       spi_clock;
    logic       spi_dc;
    logic       spi_mosi;
    logic       get;
    logic       clear;
    logic [8:0] out;
    logic       empty;
    logic       overrun;
`ifdef SPI_DISPLAY_RX_STATS_EN
    logic [15:0] bytes;
    logic [7:0]  aborts;

    modport master (output spi_cs_n, spi_clock, spi_dc, spi_mosi, get, clear,
                    input  out, empty, overrun, bytes, aborts);
    modport slave  (input  spi_cs_n, spi_clock, spi_dc, spi_mosi, get, clear,
                    output out, empty, overrun, bytes, aborts);
`else
    modport master (output spi_cs_n, spi_clock, spi_dc, spi_mosi, get, clear,
                    input  out, empty, overrun);
    modport slave  (input  spi_cs_n, spi_clock, spi_dc, spi_mosi, get, clear,
                    output out, empty, overrun);
`endif
endinterface

// File: rtl/spi_display_rx.sv
// Oversampling SPI display-link receiver: deserializes {dc, byte} words into a small FIFO.
// Define SPI_DISPLAY_RX_STATS_EN to add the bytes/aborts statistics counters.
module spi_display_rx #(
    parameter int AW   = 2,
    parameter int SYNC = 2
) (
    input  logic           clock,
    input  logic           reset_n,
    spi_display_rx_if.slave bus
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC-1:0] cs_sync, clk_sync, dc_sync, mosi_sync;
    logic            s_clk_d;
    logic            s_cs_n, s_clk, s_dc, s_mosi, rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            clk_sync  <= '0;
            dc_sync   <= '0;
            mosi_sync <= '0;
            s_clk_d   <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC-2:0], bus.spi_cs_n};
            clk_sync  <= {clk_sync[SYNC-2:0], bus.spi_clock};
            dc_sync   <= {dc_sync[SYNC-2:0], bus.spi_dc};
            mosi_sync <= {mosi_sync[SYNC-2:0], bus.spi_mosi};
            s_clk_d   <= clk_sync[SYNC-1];
        end
    end

    assign s_cs_n = cs_sync[SYNC-1];
    assign s_clk  = clk_sync[SYNC-1];
    assign s_dc   = dc_sync[SYNC-1];
    assign s_mosi = mosi_sync[SYNC-1];
    assign rise   = s_clk & ~s_clk_d;

    // Deserializer: the completed word is registered one cycle before the FIFO write
    state_t     state_q, state_n;
    logic [2:0] count_q, count_n;
    logic [6:0] shift_q, shift_n;
    logic       wr_vld_p1, wr_vld_n;
    logic [8:0] word_p1, word_n;
    logic       abort_n;

    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        shift_n  = shift_q;
        wr_vld_n = 1'b0;
        word_n   = word_p1;
        abort_n  = 1'b0;
        case (state_q)
            IDLE: begin
                count_n = 3'd0;
                if (!s_cs_n) state_n = SHIFT;
            end
            SHIFT: begin
                if (s_cs_n) begin
                    state_n = IDLE;
                    count_n = 3'd0;
                    abort_n = (count_q != 3'd0);
                end else if (rise) begin
                    shift_n = {shift_q[5:0], s_mosi};
                    if (count_q == 3'd7) begin
                        wr_vld_n = 1'b1;
                        word_n   = {s_dc, shift_q, s_mosi};
                        count_n  = 3'd0;
                    end else begin
                        count_n = count_q + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= 3'd0;
            wr_vld_p1 <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            wr_vld_p1 <= wr_vld_n;
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_n;
        word_p1 <= word_n;
    end

    // FIFO: AW+1 bit pointers, extra MSB distinguishes full from empty
    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, pop, push, drop, overrun_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = bus.get & ~empty;
    assign push  = wr_vld_p1 & (~full | pop);
    assign drop  = wr_vld_p1 & full & ~pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= word_p1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overrun_q <= drop | (overrun_q & ~bus.clear);
        end
    end

    assign bus.out     = mem[rd_ptr[AW-1:0]];
    assign bus.empty   = empty;
    assign bus.overrun = overrun_q;

`ifdef SPI_DISPLAY_RX_STATS_EN
    logic [15:0] bytes_q;
    logic [7:0]  aborts_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bytes_q  <= '0;
            aborts_q <= '0;
        end else if (bus.clear) begin
            bytes_q  <= '0;
            aborts_q <= '0;
        end else begin
            if (push)    bytes_q  <= bytes_q + 16'd1;
            if (abort_n) aborts_q <= aborts_q + 8'd1;
        end
    end

    assign bus.bytes  = bytes_q;
    assign bus.aborts = aborts_q;
`else
    logic unused_abort;
    assign unused_abort = abort_n;
`endif
endmodule

// File: tb/tb_spi_display_rx.sv
// Randomized bench for spi_display_rx with a queue-level reference model plus literal checks.
module tb_spi_display_rx;
    localparam int AW    = 2;
    localparam int SYNC  = 2;
    localparam int DEPTH = 1 << AW;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    spi_display_rx_if bus ();

    spi_display_rx #(.AW(AW), .SYNC(SYNC)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    logic [8:0] mq[$];
    bit         m_ov;
    int         pend_t[$];
    logic [8:0] pend_w[$];
    logic [15:0] m_bytes;

    // stimulus controls
    bit rand_get  = 0;
    bit rand_hold = 0;
    int pulse_cyc = -1;
    int last_rise = 0;
    int fall_cyc  = -1;
    bit prev_empty = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // model: occupancy-limited queue fed DEPTH-independent by scheduled writes
    always @(posedge clock) begin
        bit pop, wr, full, set;
        logic [8:0] w;
        cyc = cyc + 1;
        if (!reset_n) begin
            mq.delete();
            m_ov = 0;
            pend_t.delete();
            pend_w.delete();
            m_bytes = '0;
        end else begin
            pop  = bus.get && (mq.size() > 0);
            full = (mq.size() == DEPTH);
            wr   = 0;
            w    = '0;
            if (pend_t.size() > 0 && pend_t[0] == cyc) begin
                wr = 1;
                w  = pend_w[0];
                void'(pend_t.pop_front());
                void'(pend_w.pop_front());
            end
            if (pop) void'(mq.pop_front());
            set = 0;
            if (wr) begin
                if (full && !pop) set = 1;
                else begin
                    mq.push_back(w);
                    m_bytes = m_bytes + 16'd1;
                end
            end
            if (bus.clear) m_bytes = '0;
            m_ov = set | (m_ov & ~bus.clear);
        end
    end

    always @(negedge clock) begin
        #1;
        if (!reset_n) begin
            chk("rst_empty", 32'(bus.empty), 32'd1);
            chk("rst_out", 32'(bus.out), 32'h000);
            chk("rst_overrun", 32'(bus.overrun), 32'd0);
        end else begin
            chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
            if (mq.size() > 0) chk("out", 32'(bus.out), 32'(mq[0]));
            chk("overrun", 32'(bus.overrun), 32'(m_ov));
`ifdef SPI_DISPLAY_RX_STATS_EN
            chk("bytes", 32'(bus.bytes), 32'(m_bytes));
`endif
        end
        if (prev_empty && !bus.empty) fall_cyc = cyc;
        prev_empty = bus.empty;
    end

    task automatic tick();
        @(negedge clock);
        bus.get   = rand_get ? ($urandom_range(0, 3) == 0) : (cyc == pulse_cyc);
        bus.clear = rand_get ? ($urandom_range(0, 15) == 0) : 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    function automatic int hold();
        return rand_hold ? SYNC + 1 + int'($urandom_range(0, 2)) : SYNC + 1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic dc, input int nbits, input bit pulse);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = b[7-i];
            bus.spi_dc   = dc;
            wait_n(hold());
            bus.spi_clock = 1'b1;
            if (i == 7) begin
                pend_t.push_back(cyc + SYNC + 2);
                pend_w.push_back({dc, b});
                last_rise = cyc;
                if (pulse) pulse_cyc = cyc + SYNC + 1;
            end
            wait_n(hold());
            bus.spi_clock = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        wait_n(hold());
    endtask

    task automatic cs_high();
        wait_n(hold());
        bus.spi_cs_n = 1'b1;
        wait_n(hold());
    endtask

    task automatic pop_expect(input string name, input logic [8:0] exp);
        tick();
        chk(name, {22'd0, bus.empty, bus.out}, {22'd0, 1'b0, exp});
        bus.get = 1'b1;
        tick();
    endtask

    task automatic pulse_clear();
        tick();
        bus.clear = 1'b1;
        tick();
    endtask

    task automatic drain();
        rand_get  = 0;
        rand_hold = 0;
        pulse_cyc = -1;
        wait_n(SYNC + 4);
        for (int k = 0; k < 4 * DEPTH; k++) begin
            tick();
            if (bus.empty) break;
            bus.get = 1'b1;
        end
        pulse_clear();
        tick();
        chk("drain_empty", 32'(bus.empty), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycles=%0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.spi_cs_n  = 1'b1;
        bus.spi_clock = 1'b0;
        bus.spi_dc    = 1'b0;
        bus.spi_mosi  = 1'b0;
        bus.get       = 1'b0;
        bus.clear     = 1'b0;
        wait_n(3);
        chk("reset_empty", 32'(bus.empty), 32'd1);
        reset_n = 1'b1;
        wait_n(3);

        // two bytes, command then data
        cs_low();
        send_byte(8'h2A, 1'b0, 8, 0);
        send_byte(8'hC5, 1'b1, 8, 0);
        cs_high();
        wait_n(4);
        pop_expect("t1_first", 9'h02A);
        pop_expect("t1_second", 9'h1C5);
        tick();
        chk("t1_empty", 32'(bus.empty), 32'd1);

        // write latency from the pin
        fall_cyc = -1;
        cs_low();
        send_byte(8'h3C, 1'b1, 8, 0);
        cs_high();
        chk("t2_latency", 32'(fall_cyc - last_rise), 32'(SYNC + 2));
        pop_expect("t2_word", 9'h13C);
        drain();

        // overflow past depth
        cs_low();
        for (int j = 1; j <= 5; j++) send_byte(8'(j), 1'b0, 8, 0);
        cs_high();
        wait_n(4);
        chk("t3_overrun_set", 32'(bus.overrun), 32'd1);
        pulse_clear();
        chk("t3_overrun_clr", 32'(bus.overrun), 32'd0);
        for (int j = 1; j <= 4; j++) pop_expect("t3_pop", 9'(j));
        tick();
        chk("t3_empty", 32'(bus.empty), 32'd1);
        drain();

        // aborted partial byte then a full one
        cs_low();
        send_byte(8'hA0, 1'b0, 3, 0);
        bus.spi_cs_n = 1'b1;
        wait_n(hold());
        cs_low();
        send_byte(8'h81, 1'b0, 8, 0);
        cs_high();
        wait_n(4);
`ifdef SPI_DISPLAY_RX_STATS_EN
        chk("t4_aborts", 32'(bus.aborts), 32'd1);
        chk("t4_bytes", 32'(bus.bytes), 32'd1);
`endif
        pop_expect("t4_word", 9'h081);
        tick();
        chk("t4_empty", 32'(bus.empty), 32'd1);
        drain();

        // full FIFO with a pop on the same edge as the fifth write
        cs_low();
        for (int j = 1; j <= 4; j++) send_byte(8'(j), 1'b0, 8, 0);
        send_byte(8'h05, 1'b0, 8, 1);
        cs_high();
        pulse_cyc = -1;
        wait_n(4);
        chk("t5_overrun", 32'(bus.overrun), 32'd0);
        for (int j = 2; j <= 5; j++) pop_expect("t5_pop", 9'(j));
        tick();
        chk("t5_empty", 32'(bus.empty), 32'd1);
        drain();

        // reset in the middle of a byte
        cs_low();
        send_byte(8'hFF, 1'b1, 4, 0);
        tick();
        reset_n       = 1'b0;
        bus.spi_cs_n  = 1'b1;
        bus.spi_clock = 1'b0;
        wait_n(2);
        chk("t6_rst_empty", 32'(bus.empty), 32'd1);
        wait_n(2);
        reset_n = 1'b1;
        wait_n(3);
        cs_low();
        send_byte(8'h7E, 1'b0, 8, 0);
        cs_high();
        wait_n(4);
        pop_expect("t6_word", 9'h07E);
        tick();
        chk("t6_empty", 32'(bus.empty), 32'd1);
        drain();

        // randomized frames, random pops, clears and phase lengths
        rand_get  = 1;
        rand_hold = 1;
        repeat (25) begin
            cs_low();
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++)
                send_byte(8'($urandom), 1'($urandom_range(0, 1)), 8, 0);
            if ($urandom_range(0, 3) == 0)
                send_byte(8'($urandom), 1'b0, $urandom_range(1, 7), 0);
            cs_high();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
